hilo_mult_ctrl: RTL and testbench

- Sequential stage directly downstream of the combinational multiply unit; it also drives that unit's operands.
- Accepts mult/multu issue from EX and registers the operands and sign control that feed the multiplier.
- Holds a busy window of LATENCY cycles, then commits the 2*WIDTH-bit product into the architectural HI/LO registers.
- Services mthi/mtlo writes, exposes HI/LO for mfhi/mflo, and raises busy for the hazard unit to stall on.

---
 rtl/hilo_mult_ctrl.sv | 123 ++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: registers multiply operands for a combinational multiplier,
// holds busy for LATENCY cycles, then commits the 2*WIDTH-bit product into
// HI/LO. Also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.
// Optional macro HILO_MADD_ACC_EN adds an acc input; when it is set at issue,
// the commit accumulates into {hi,lo} (madd/maddu) instead of overwriting it.
module hilo_mult_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               flush,
`ifdef HILO_MADD_ACC_EN
  input  logic               acc,
`endif
  output logic [WIDTH-1:0]   mul_srcA,
  output logic [WIDTH-1:0]   mul_srcB,
  output logic               mul_ctrl,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       load;    // accept a new multiply this edge
  logic       commit;  // write the product into HI/LO this edge

`ifdef HILO_MADD_ACC_EN
  logic       acc_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-edge control; flush beats both start and commit
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and latency counter; operands hold steady while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_srcA <= '0;
      mul_srcB <= '0;
      mul_ctrl <= 1'b0;
      cnt      <= 4'd0;
`ifdef HILO_MADD_ACC_EN
      acc_q    <= 1'b0;
`endif
    end else if (load) begin
      mul_srcA <= op_a;
      mul_srcB <= op_b;
      mul_ctrl <= sign;
      cnt      <= 4'(LATENCY);
`ifdef HILO_MADD_ACC_EN
      acc_q    <= acc;
`endif
    end else if (state == BUSY) begin
      cnt      <= flush ? 4'd0 : cnt - 4'd1;
    end
  end

  // HI/LO: product commit while busy, mthi/mtlo only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
`ifdef HILO_MADD_ACC_EN
      if (acc_q) {hi, lo} <= {hi, lo} + mul_result;
      else       {hi, lo} <= mul_result;
`else
      {hi, lo} <= mul_result;
`endif
    end else if (state == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // done pulses for the one cycle after the commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= commit;
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: models the combinational multiplier and tracks
// the architectural HI/LO value from issued operations.
module tb_hilo_mult_ctrl;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, sign, flush, hi_we, lo_we;
  logic [W-1:0]   op_a, op_b, wdata;
  logic [W-1:0]   mul_srcA, mul_srcB, hi, lo;
  logic           mul_ctrl, busy, done;
  logic [2*W-1:0] mul_result;
  logic           acc;

  int cmp  = 0;
  int errs = 0;
  logic [W-1:0] mh, ml;  // reference HI/LO

  always #5 clk = ~clk;

  hilo_mult_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .op_a(op_a), .op_b(op_b), .flush(flush),
`ifdef HILO_MADD_ACC_EN
    .acc(acc),
`endif
    .mul_srcA(mul_srcA), .mul_srcB(mul_srcB), .mul_ctrl(mul_ctrl),
    .mul_result(mul_result), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, b, input logic s);
    logic [2*W-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  // Combinational multiplier sitting outside the block
  assign mul_result = prod(mul_srcA, mul_srcB, mul_ctrl);

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cmp++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL reset_busy_done busy=%b done=%b want 0 0", busy, done); end
    cmp++; if (hi !== '0 || lo !== '0) begin errs++; $display("FAIL reset_hilo hi=%h lo=%h want 0 0", hi, lo); end
    cmp++; if (mul_srcA !== '0 || mul_srcB !== '0 || mul_ctrl !== 1'b0) begin errs++; $display("FAIL reset_ops a=%h b=%h c=%b want 0", mul_srcA, mul_srcB, mul_ctrl); end
  endtask

  task automatic write_hilo(input logic hw, lw, input logic [W-1:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    cyc();
    hi_we = 0; lo_we = 0; wdata = $urandom;
    if (hw) mh = d;
    if (lw) ml = d;
    cmp++; if (hi !== mh || lo !== ml) begin errs++; $display("FAIL mthi_mtlo hi=%h lo=%h want %h %h", hi, lo, mh, ml); end
  endtask

  // Issue one multiply; flush_at>=0 raises flush during that busy cycle,
  // spur injects a start plus mthi/mtlo during the 2nd busy cycle.
  task automatic do_op(input logic [W-1:0] a, b, input logic s, input logic accv,
                       input int flush_at, input logic spur);
    logic [2*W-1:0] p;
    p = prod(a, b, s);
    op_a = a; op_b = b; sign = s; acc = accv; start = 1;
    cyc();
    start = 0; op_a = $urandom; op_b = $urandom; sign = ~s; acc = ~accv;
    for (int k = 0; k < LAT; k++) begin
      cmp++; if (busy !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL op_busy k=%0d busy=%b done=%b want 1 0", k, busy, done); end
      cmp++; if (mul_srcA !== a || mul_srcB !== b || mul_ctrl !== s) begin errs++; $display("FAIL op_hold k=%0d a=%h b=%h c=%b want %h %h %b", k, mul_srcA, mul_srcB, mul_ctrl, a, b, s); end
      cmp++; if (hi !== mh || lo !== ml) begin errs++; $display("FAIL op_hilo_busy k=%0d hi=%h lo=%h want %h %h", k, hi, lo, mh, ml); end
      if (k == flush_at) flush = 1;
      if (spur && k == 1) begin
        start = 1; op_a = $urandom; op_b = $urandom; hi_we = 1; lo_we = 1; wdata = $urandom;
      end
      cyc();
      start = 0; hi_we = 0; lo_we = 0;
      if (k == flush_at) begin
        flush = 0;
        cmp++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL flush_idle busy=%b done=%b want 0 0", busy, done); end
        cmp++; if (hi !== mh || lo !== ml) begin errs++; $display("FAIL flush_hilo hi=%h lo=%h want %h %h", hi, lo, mh, ml); end
        cyc();
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL flush_no_done done=%b want 0", done); end
        return;
      end
    end
    if (accv) {mh, ml} = {mh, ml} + p;
    else      {mh, ml} = p;
    cmp++; if (busy !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL commit_flags busy=%b done=%b want 0 1", busy, done); end
    cmp++; if (hi !== mh || lo !== ml) begin errs++; $display("FAIL commit_hilo hi=%h lo=%h want %h %h", hi, lo, mh, ml); end
    cyc();
    cmp++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_multu();
    do_op(32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, -1, 1'b0);
    cmp++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin errs++; $display("FAIL multu_const hi=%h lo=%h want 00000001 fffffffe", hi, lo); end
  endtask

  task automatic test_mult_signed();
    do_op(32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b0, -1, 1'b0);
    cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin errs++; $display("FAIL mult_const hi=%h lo=%h want ffffffff fffffff1", hi, lo); end
  endtask

  task automatic test_flush();
    write_hilo(1'b1, 1'b0, 32'h12345678);
    do_op(32'h11, 32'h22, 1'b0, 1'b0, 1, 1'b0);
    cmp++; if (hi !== 32'h12345678) begin errs++; $display("FAIL flush_keep_hi hi=%h want 12345678", hi); end
    // flush and start together while idle: start is dropped
    op_a = 32'h5; op_b = 32'h6; start = 1; flush = 1;
    cyc();
    start = 0; flush = 0;
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_beats_start busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    write_hilo(1'b1, 1'b1, 32'h0);
    do_op(32'd3, 32'd4, 1'b0, 1'b0, -1, 1'b1);
    cmp++; if (hi !== 32'h0 || lo !== 32'h0000000C) begin errs++; $display("FAIL ignore_start hi=%h lo=%h want 0 0000000c", hi, lo); end
    do_op(32'd7, 32'd7, 1'b1, 1'b0, -1, 1'b0);
    // mthi coinciding with start: the later commit wins
    op_a = 32'd2; op_b = 32'd9; sign = 0; start = 1; hi_we = 1; wdata = 32'hDEADBEEF;
    cyc();
    start = 0; hi_we = 0;
    cmp++; if (hi !== 32'hDEADBEEF || busy !== 1'b1) begin errs++; $display("FAIL we_with_start hi=%h busy=%b want deadbeef 1", hi, busy); end
    repeat (LAT) cyc();
    mh = 32'h0; ml = 32'd18;
    cmp++; if (hi !== mh || lo !== ml) begin errs++; $display("FAIL we_overwritten hi=%h lo=%h want %h %h", hi, lo, mh, ml); end
  endtask

  task automatic test_async_reset();
    write_hilo(1'b1, 1'b0, 32'hDEADBEEF);
    op_a = 32'hABCD; op_b = 32'h1234; sign = 0; start = 1;
    cyc(); start = 0;
    cyc();
    #2 rst = 1; #1;
    mh = '0; ml = '0;
    cmp++; if (busy !== 1'b0 || hi !== '0 || lo !== '0 || mul_srcA !== '0) begin errs++; $display("FAIL async_rst busy=%b hi=%h lo=%h a=%h want 0", busy, hi, lo, mul_srcA); end
    #2 rst = 0;
    repeat (LAT) cyc();
    cmp++; if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin errs++; $display("FAIL rst_discard busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo); end
  endtask

`ifdef HILO_MADD_ACC_EN
  task automatic test_madd();
    write_hilo(1'b1, 1'b1, 32'h0);
    write_hilo(1'b0, 1'b1, 32'hFFFFFFFF);
    do_op(32'd1, 32'd1, 1'b0, 1'b1, -1, 1'b0);
    cmp++; if (hi !== 32'h1 || lo !== 32'h0) begin errs++; $display("FAIL madd_const hi=%h lo=%h want 00000001 0", hi, lo); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic accv;
      int   fa;
      accv = 1'b0;
`ifdef HILO_MADD_ACC_EN
      accv = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 2) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), accv, fa, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1; start = 0; sign = 0; flush = 0; hi_we = 0; lo_we = 0; acc = 0;
    op_a = '0; op_b = '0; wdata = '0; mh = '0; ml = '0;
    #12;
    test_reset();
    #3 rst = 0;
    cyc();
    test_multu();
    test_mult_signed();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef HILO_MADD_ACC_EN
    test_madd();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
